blocpu_loader: RTL and testbench
================================

Name: blocpu_loader

Overview:
- Host-side program-load and run controller for the blocpu core.
- Resets the core, streams a program from a host word interface into core instruction memory (via the core's posedge-triggered instruction-write port), starts execution, and reports completion when the core drops running.
- Sits between the host/test harness and one blocpu_core instance; the only agent that drives the core's reset, running and programming inputs.

Parameters:
- INSTRUCTION_WIDTH, 12, instruction word width; matches the core.
- ADDRESS_WIDTH, 16, instruction address width; matches the core's double-word address.
- MAX_WORDS, 4096, maximum program length in words; 1..2^ADDRESS_WIDTH.
- RESET_CYCLES, 4, cycles out_core_reset is held high; must be >= 1.
- WATCHDOG_CYCLES, 65535, run-time limit in cycles; used only with the optional feature.

Ports:
- in_clock  input  1  system clock; all state updates on posedge.
- in_reset_n  input  1  asynchronous, active-low reset.
- in_start  input  1  level; sampled in IDLE/DONE/ERROR to begin a load; ignored otherwise.
- in_abort  input  1  level; forces ERROR(abort) from any busy state.
- in_host_word  input  INSTRUCTION_WIDTH  program word.
- in_host_valid  input  1  in_host_word valid.
- in_host_last  input  1  qualifies the final program word.
- out_host_ready  output  1  controller accepts a word this cycle.
- out_core_reset  output  1  drives core in_reset.
- out_core_run  output  1  drives core in_running; one-cycle pulse.
- in_core_running  input  1  core out_running.
- out_instruction  output  INSTRUCTION_WIDTH  drives core in_instruction.
- out_instruction_address  output  ADDRESS_WIDTH  drives core in_instruction_address.
- out_instruction_write  output  1  drives core in_instruction_write.
- out_busy  output  1  high in every state except IDLE, DONE, ERROR.
- out_done  output  1  high in DONE.
- out_error  output  2  0 none, 1 overflow, 2 watchdog, 3 abort; valid in ERROR, else 0.
- out_word_count  output  ADDRESS_WIDTH  words written in the current/last load.

Behaviour:
- Reset (in_reset_n=0, asynchronous): state IDLE. All outputs 0; word counter 0; address 0.
- IDLE/DONE/ERROR + in_start=1:
  - clear word counter, address and error;
  - go to RESET with out_core_reset=1 for exactly RESET_CYCLES cycles, then LOAD_WAIT.
- LOAD_WAIT:
  - out_host_ready=1. Handshake fires when valid&ready.
  - On fire, latch in_host_word into out_instruction and the last flag, then go to WR_SETUP.
  - On a fire with out_word_count==MAX_WORDS: go to ERROR, code 1; the word is not written.
- Per-word write, 3 cycles, ready=0 throughout:
  - WR_SETUP: address and data stable, write=0.
  - WR_STROBE: write=1.
  - WR_HOLD: write=0, data and address still stable; word counter +1.
  - After WR_HOLD: if last, go to START; else increment address and return to LOAD_WAIT.
  - Sustained throughput: 1 word per 4 cycles.
  - Address never wraps; the MAX_WORDS check precedes the write.
- START: out_core_run=1 for one cycle, then WAIT_HIGH.
- WAIT_HIGH: in_core_running=1 moves to RUN.
- RUN: in_core_running falling to 0 moves to DONE.
- DONE: out_done=1. Outputs to the core idle at 0. Program memory left intact.
- ERROR: out_core_reset pulses high for one cycle on entry; the core is stopped. Code is held until the next start.
- in_abort=1 in any busy state: next cycle ERROR code 3. Abort has priority over every other transition, including a simultaneous handshake fire or watchdog expiry.
- in_start during a busy state: ignored.
- in_start and in_abort together in IDLE: start wins; abort is not applicable when idle.
- in_host_valid outside LOAD_WAIT: ignored, no data loss; the host holds the word.
- out_core_run and out_instruction_write are never high in the same cycle.
- out_core_reset is never high while out_instruction_write is high.
- Reset asserted mid-load: asynchronous return to IDLE; the partial program stays in core memory but is not run.

Optional Feature:
- BLOCPU_LOADER_WATCHDOG_EN
- Defined:
  - a cycle counter runs in WAIT_HIGH and RUN;
  - when it reaches WATCHDOG_CYCLES without in_core_running falling, go to ERROR code 2, pulsing out_core_reset.
- Undefined:
  - no counter logic;
  - WAIT_HIGH and RUN wait indefinitely, exiting only on the core-running edge, abort or reset;
  - error code 2 never produced.

Test Plan:
- 3-word program 0x801,0x902,0x300 (last on the 3rd), host valid every cycle -> the following, then done=1:
  - reset high 4 cycles;
  - writes at addresses 0,1,2 with those words, each write pulse preceded and followed by one stable cycle;
  - word_count=3;
  - one run pulse;
  - core running high then low.
- MAX_WORDS=2, 3 words offered -> 2 writes, third word accepted but not written, error=1, reset pulse, done=0.
- Abort during WR_STROBE of word 1 -> next cycle error=3, busy=0, no further write pulses.
- Watchdog defined with WATCHDOG_CYCLES=20, core program loops forever (running stays 1) -> error=2 exactly 20 cycles after entering WAIT_HIGH, reset pulse.
- Host valid toggling 1,0,0,1 with 2 words -> ready only in LOAD_WAIT, both words written in order, no duplicate writes.
- Async reset asserted mid-RUN, then start again with a 1-word program -> all outputs 0 during reset; second load completes with word_count=1, done=1.

Source files
------------

// File: rtl/blocpu_loader_if.sv
// Host word interface for blocpu_loader: program words streamed by the host.
//
// Handshake: a word transfers on a rising clock edge where in_host_valid and
// out_host_ready are both high. The host keeps in_host_word / in_host_last
// stable while valid is high and ready is low; the loader never drops a word
// that was not transferred. Ready does not depend on valid.
interface blocpu_loader_if #(
  parameter int INSTRUCTION_WIDTH = 12
) ();
  logic [INSTRUCTION_WIDTH-1:0] in_host_word;
  logic                         in_host_valid;
  logic                         in_host_last;
  logic                         out_host_ready;

  modport slave (
    input  in_host_word,
    input  in_host_valid,
    input  in_host_last,
    output out_host_ready
  );

  modport master (
    output in_host_word,
    output in_host_valid,
    output in_host_last,
    input  out_host_ready
  );
endinterface

// File: rtl/blocpu_loader.sv
// blocpu_loader: resets the blocpu core, streams a program into its
// instruction memory through the posedge-triggered write port, starts it and
// reports completion when the core drops running.
// Optional feature macro: BLOCPU_LOADER_WATCHDOG_EN (run-time watchdog,
// error code 2 after WATCHDOG_CYCLES cycles in WAIT_HIGH/RUN).
module blocpu_loader #(
  parameter int INSTRUCTION_WIDTH = 12,
  parameter int ADDRESS_WIDTH     = 16,
  parameter int MAX_WORDS         = 4096,
  parameter int RESET_CYCLES      = 4,
  parameter int WATCHDOG_CYCLES   = 65535
) (
  input  logic                         in_clock,
  input  logic                         in_reset_n,
  input  logic                         in_start,
  input  logic                         in_abort,
  blocpu_loader_if.slave               host,
  output logic                         out_core_reset,
  output logic                         out_core_run,
  input  logic                         in_core_running,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [ADDRESS_WIDTH-1:0]     out_instruction_address,
  output logic                         out_instruction_write,
  output logic                         out_busy,
  output logic                         out_done,
  output logic [1:0]                   out_error,
  output logic [ADDRESS_WIDTH-1:0]     out_word_count,
  output logic [3:0]                   out_debug_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RESET     = 4'd1,
    S_LOAD_WAIT = 4'd2,
    S_WR_SETUP  = 4'd3,
    S_WR_STROBE = 4'd4,
    S_WR_HOLD   = 4'd5,
    S_START     = 4'd6,
    S_WAIT_HIGH = 4'd7,
    S_RUN       = 4'd8,
    S_DONE      = 4'd9,
    S_ERROR     = 4'd10
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_WATCHDOG = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

  // Word counter is one bit wider than the address so MAX_WORDS up to
  // 2^ADDRESS_WIDTH can be represented and compared without wrapping.
  localparam int                    CNT_W   = ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0]      MAX_W   = CNT_W'(MAX_WORDS);
  localparam int                    RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]       RC_LAST = RC_W'(RESET_CYCLES - 1);

  state_t                         state_q, state_d;
  logic [RC_W-1:0]                rst_cnt_q, rst_cnt_d;
  logic [ADDRESS_WIDTH-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
  logic                           last_q, last_d;
  logic [1:0]                     err_q, err_d;
  logic                           err_entry_q, err_entry_d;
  logic                           busy;

`ifdef BLOCPU_LOADER_WATCHDOG_EN
  localparam int                  WD_W    = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0]     WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0]                wd_q, wd_d;
`else
  logic                           unused_watchdog_cfg;
  assign unused_watchdog_cfg = ^WATCHDOG_CYCLES;
`endif

  assign busy = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

  // Next-state logic: abort beats every other transition out of a busy state.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    last_d      = last_q;
    err_d       = err_q;
`ifdef BLOCPU_LOADER_WATCHDOG_EN
    wd_d        = wd_q;
`endif
    if (busy && in_abort) begin
      state_d = S_ERROR;
      err_d   = ERR_ABORT;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (in_start) begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
            addr_d    = '0;
            cnt_d     = '0;
            instr_d   = '0;
            last_d    = 1'b0;
            err_d     = ERR_NONE;
          end
        end
        S_RESET: begin
          if (rst_cnt_q == RC_LAST) state_d = S_LOAD_WAIT;
          else                      rst_cnt_d = rst_cnt_q + 1'b1;
        end
        S_LOAD_WAIT: begin
          // Ready is high here, so valid alone means the handshake fires.
          if (host.in_host_valid) begin
            if (cnt_q == MAX_W) begin
              state_d = S_ERROR;
              err_d   = ERR_OVERFLOW;
            end else begin
              instr_d = host.in_host_word;
              last_d  = host.in_host_last;
              state_d = S_WR_SETUP;
            end
          end
        end
        S_WR_SETUP:  state_d = S_WR_STROBE;
        S_WR_STROBE: begin
          state_d = S_WR_HOLD;
          cnt_d   = cnt_q + 1'b1;
        end
        S_WR_HOLD: begin
          if (last_q) begin
            state_d = S_START;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_LOAD_WAIT;
          end
        end
        S_START: begin
          state_d = S_WAIT_HIGH;
`ifdef BLOCPU_LOADER_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
        S_WAIT_HIGH: begin
`ifdef BLOCPU_LOADER_WATCHDOG_EN
          wd_d = wd_q + 1'b1;
          if (wd_q == WD_LAST) begin
            state_d = S_ERROR;
            err_d   = ERR_WATCHDOG;
          end else
`endif
          if (in_core_running) state_d = S_RUN;
        end
        S_RUN: begin
          if (!in_core_running) state_d = S_DONE;
`ifdef BLOCPU_LOADER_WATCHDOG_EN
          else if (wd_q == WD_LAST) begin
            state_d = S_ERROR;
            err_d   = ERR_WATCHDOG;
          end
          wd_d = wd_q + 1'b1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
    // One-cycle core reset pulse on every entry into ERROR.
    err_entry_d = (state_d == S_ERROR) && (state_q != S_ERROR);
  end

  // State and datapath registers.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      instr_q     <= '0;
      last_q      <= 1'b0;
      err_q       <= ERR_NONE;
      err_entry_q <= 1'b0;
`ifdef BLOCPU_LOADER_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      last_q      <= last_d;
      err_q       <= err_d;
      err_entry_q <= err_entry_d;
`ifdef BLOCPU_LOADER_WATCHDOG_EN
      wd_q        <= wd_d;
`endif
    end
  end

  // Outputs decoded from state; core data/address lines idle at 0 outside
  // the three write phases so the core only ever sees a stable word around
  // the strobe.
  always_comb begin
    logic wr_phase;
    wr_phase                = (state_q == S_WR_SETUP) || (state_q == S_WR_STROBE) ||
                              (state_q == S_WR_HOLD);
    host.out_host_ready     = (state_q == S_LOAD_WAIT);
    out_core_reset          = (state_q == S_RESET) || ((state_q == S_ERROR) && err_entry_q);
    out_core_run            = (state_q == S_START);
    out_instruction_write   = (state_q == S_WR_STROBE);
    out_instruction         = wr_phase ? instr_q : '0;
    out_instruction_address = wr_phase ? addr_q : '0;
    out_busy                = busy;
    out_done                = (state_q == S_DONE);
    out_error               = (state_q == S_ERROR) ? err_q : ERR_NONE;
    out_word_count          = cnt_q[ADDRESS_WIDTH-1:0];
    out_debug_state         = state_q;
  end

endmodule

// File: tb/tb_blocpu_loader.sv
// Directed bench for blocpu_loader: cycle table for a full 3-word load/run,
// then hand sequences for overflow, abort, host stalls, watchdog and async
// reset. Instance a uses MAX_WORDS=4096, instance b MAX_WORDS=2; both share
// stimulus and WATCHDOG_CYCLES=20.
module tb_blocpu_loader;

  logic        in_clock;
  logic        in_reset_n;
  logic        in_start;
  logic        in_abort;
  logic        in_core_running;
  logic [11:0] host_word;
  logic        host_valid;
  logic        host_last;

  logic        rst_a, run_a, wr_a, busy_a, done_a;
  logic [11:0] instr_a;
  logic [15:0] addr_a, cnt_a;
  logic [1:0]  err_a;
  logic [3:0]  dbg_a;
  logic        rst_b, run_b, wr_b, busy_b, done_b;
  logic [11:0] instr_b;
  logic [15:0] addr_b, cnt_b;
  logic [1:0]  err_b;
  logic [3:0]  dbg_b;

  blocpu_loader_if #(.INSTRUCTION_WIDTH(12)) hif_a ();
  blocpu_loader_if #(.INSTRUCTION_WIDTH(12)) hif_b ();

  assign hif_a.in_host_word  = host_word;
  assign hif_a.in_host_valid = host_valid;
  assign hif_a.in_host_last  = host_last;
  assign hif_b.in_host_word  = host_word;
  assign hif_b.in_host_valid = host_valid;
  assign hif_b.in_host_last  = host_last;

  blocpu_loader #(.MAX_WORDS(4096), .WATCHDOG_CYCLES(20)) dut_a (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .in_start(in_start), .in_abort(in_abort),
    .host(hif_a.slave), .out_core_reset(rst_a), .out_core_run(run_a),
    .in_core_running(in_core_running), .out_instruction(instr_a),
    .out_instruction_address(addr_a), .out_instruction_write(wr_a), .out_busy(busy_a),
    .out_done(done_a), .out_error(err_a), .out_word_count(cnt_a), .out_debug_state(dbg_a)
  );

  blocpu_loader #(.MAX_WORDS(2), .WATCHDOG_CYCLES(20)) dut_b (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .in_start(in_start), .in_abort(in_abort),
    .host(hif_b.slave), .out_core_reset(rst_b), .out_core_run(run_b),
    .in_core_running(in_core_running), .out_instruction(instr_b),
    .out_instruction_address(addr_b), .out_instruction_write(wr_b), .out_busy(busy_b),
    .out_done(done_b), .out_error(err_b), .out_word_count(cnt_b), .out_debug_state(dbg_b)
  );

  logic [51:0] obs_a, obs_b;
  assign obs_a = {rst_a, wr_a, run_a, hif_a.out_host_ready, busy_a, done_a, err_a,
                  addr_a, instr_a, cnt_a};
  assign obs_b = {rst_b, wr_b, run_b, hif_b.out_host_ready, busy_b, done_b, err_b,
                  addr_b, instr_b, cnt_b};

  // ---------------- clock / reset ----------------
  initial begin
    in_clock = 1'b0;
    forever #5 in_clock = ~in_clock;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  bit sb_en = 1'b0;
  logic [27:0] exp_q[$];
  logic [27:0] sb_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard: every write strobe of instance a is matched against the
  // expected {address, word} queue; illegal output overlaps are flagged.
  always @(negedge in_clock) begin
    if (in_reset_n) begin
      if (wr_a) begin
        wr_cnt_a++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected_write: got addr %0h data %0h, expected no write",
                     addr_a, instr_a);
          end else begin
            sb_exp = exp_q.pop_front();
            check("sb_write_addr_data", 64'({addr_a, instr_a}), 64'(sb_exp));
          end
        end
      end
      if (wr_b) wr_cnt_b++;
      if ((wr_a && (run_a || rst_a)) || (wr_b && (run_b || rst_b))) begin
        n_total++;
        $display("FAIL write_exclusive: got write with run/reset high, expected write alone");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge in_clock);
    #1;
  endtask

  task automatic do_reset();
    in_start        = 1'b0;
    in_abort        = 1'b0;
    in_core_running = 1'b0;
    host_valid      = 1'b0;
    host_last       = 1'b0;
    host_word       = '0;
    in_reset_n      = 1'b0;
    repeat (2) step();
    check("reset_outputs_a", 64'(obs_a), 64'd0);
    check("reset_outputs_b", 64'(obs_b), 64'd0);
    in_reset_n = 1'b1;
    step();
  endtask

  task automatic start_load();
    in_start = 1'b1;
    step();
    in_start = 1'b0;
  endtask

  // Offer one word and hold it until the selected instance accepts it.
  task automatic host_send(input logic [11:0] w, input logic l, input bit use_b);
    bit   ok;
    logic rdy;
    ok         = 1'b0;
    host_word  = w;
    host_last  = l;
    host_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge in_clock);
      rdy = use_b ? hif_b.out_host_ready : hif_a.out_host_ready;
      @(posedge in_clock);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
    check("host_send_accepted", 64'(ok), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start, valid, last;
    logic [11:0] word;
    logic        running;
    logic        rst, wr, run, rdy, busy, done;
    logic [1:0]  err;
    logic [15:0] addr;
    logic [11:0] instr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic mk(input int i, input logic st, v, l, input logic [11:0] w, input logic rn,
                    input logic rs, wr, ru, rd, bz, dn, input logic [1:0] er,
                    input logic [15:0] ad, input logic [11:0] ins, input logic [15:0] cn);
    vecs[i] = '{st, v, l, w, rn, rs, wr, ru, rd, bz, dn, er, ad, ins, cn};
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] pat;
    int         idx;
    int         wr_snap;
    bit         fired;

    do_reset();

    // Full 3-word program, host valid every cycle; one row per clock edge.
    //   st v l word   run | rst wr run rdy busy done err addr instr cnt
    mk( 0, 1,0,0,12'h000,0, 1,0,0,0,1,0,0,16'd0,12'h000,16'd0);
    mk( 1, 0,1,0,12'h801,0, 1,0,0,0,1,0,0,16'd0,12'h000,16'd0);
    mk( 2, 0,1,0,12'h801,0, 1,0,0,0,1,0,0,16'd0,12'h000,16'd0);
    mk( 3, 0,1,0,12'h801,0, 1,0,0,0,1,0,0,16'd0,12'h000,16'd0);
    mk( 4, 0,1,0,12'h801,0, 0,0,0,1,1,0,0,16'd0,12'h000,16'd0);
    mk( 5, 0,1,0,12'h801,0, 0,0,0,0,1,0,0,16'd0,12'h801,16'd0);
    mk( 6, 0,1,0,12'h902,0, 0,1,0,0,1,0,0,16'd0,12'h801,16'd0);
    mk( 7, 0,1,0,12'h902,0, 0,0,0,0,1,0,0,16'd0,12'h801,16'd1);
    mk( 8, 0,1,0,12'h902,0, 0,0,0,1,1,0,0,16'd0,12'h000,16'd1);
    mk( 9, 0,1,0,12'h902,0, 0,0,0,0,1,0,0,16'd1,12'h902,16'd1);
    mk(10, 0,1,1,12'h300,0, 0,1,0,0,1,0,0,16'd1,12'h902,16'd1);
    mk(11, 0,1,1,12'h300,0, 0,0,0,0,1,0,0,16'd1,12'h902,16'd2);
    mk(12, 0,1,1,12'h300,0, 0,0,0,1,1,0,0,16'd0,12'h000,16'd2);
    mk(13, 0,1,1,12'h300,0, 0,0,0,0,1,0,0,16'd2,12'h300,16'd2);
    mk(14, 0,0,0,12'h000,0, 0,1,0,0,1,0,0,16'd2,12'h300,16'd2);
    mk(15, 0,0,0,12'h000,0, 0,0,0,0,1,0,0,16'd2,12'h300,16'd3);
    mk(16, 0,0,0,12'h000,0, 0,0,1,0,1,0,0,16'd0,12'h000,16'd3);
    mk(17, 0,0,0,12'h000,0, 0,0,0,0,1,0,0,16'd0,12'h000,16'd3);
    mk(18, 0,0,0,12'h000,1, 0,0,0,0,1,0,0,16'd0,12'h000,16'd3);
    mk(19, 0,0,0,12'h000,1, 0,0,0,0,1,0,0,16'd0,12'h000,16'd3);
    mk(20, 0,0,0,12'h000,0, 0,0,0,0,0,1,0,16'd0,12'h000,16'd3);

    sb_en = 1'b1;
    exp_q.push_back({16'd0, 12'h801});
    exp_q.push_back({16'd1, 12'h902});
    exp_q.push_back({16'd2, 12'h300});
    for (int i = 0; i < 21; i++) begin
      in_start        = vecs[i].start;
      host_valid      = vecs[i].valid;
      host_last       = vecs[i].last;
      host_word       = vecs[i].word;
      in_core_running = vecs[i].running;
      step();
      check($sformatf("table_row_%0d", i), 64'(obs_a),
            64'({vecs[i].rst, vecs[i].wr, vecs[i].run, vecs[i].rdy, vecs[i].busy,
                 vecs[i].done, vecs[i].err, vecs[i].addr, vecs[i].instr, vecs[i].cnt}));
    end
    check("table_all_writes_seen", 64'(exp_q.size()), 64'd0);
    sb_en = 1'b0;

    // Overflow on instance b (MAX_WORDS=2): third word accepted, not written.
    do_reset();
    start_load();
    wr_snap = wr_cnt_b;
    host_send(12'hA01, 1'b0, 1'b1);
    host_send(12'hA02, 1'b0, 1'b1);
    host_send(12'hA03, 1'b1, 1'b1);
    check("ovf_err_rst_busy_done", 64'({err_b, rst_b, busy_b, done_b}), 64'({2'd1, 1'b1, 1'b0, 1'b0}));
    check("ovf_word_count", 64'(cnt_b), 64'd2);
    step();
    check("ovf_reset_pulse_ends", 64'({err_b, rst_b}), 64'({2'd1, 1'b0}));
    check("ovf_write_pulses", 64'(wr_cnt_b - wr_snap), 64'd2);

    // Abort during the write strobe of the second word.
    do_reset();
    in_start = 1'b1;
    in_abort = 1'b1;
    step();
    check("idle_start_beats_abort", 64'({rst_a, busy_a, err_a}), 64'({1'b1, 1'b1, 2'd0}));
    in_start = 1'b0;
    in_abort = 1'b0;
    host_send(12'h0AA, 1'b0, 1'b0);
    host_send(12'h0BB, 1'b0, 1'b0);
    step();
    check("abort_in_strobe", 64'({wr_a, addr_a, instr_a}), 64'({1'b1, 16'd1, 12'h0BB}));
    in_abort = 1'b1;
    step();
    check("abort_err_busy_rst", 64'({err_a, busy_a, rst_a}), 64'({2'd3, 1'b0, 1'b1}));
    in_abort   = 1'b0;
    wr_snap    = wr_cnt_a;
    host_valid = 1'b1;
    repeat (8) step();
    host_valid = 1'b0;
    check("abort_no_more_writes", 64'(wr_cnt_a - wr_snap), 64'd0);
    check("abort_code_held", 64'({err_a, hif_a.out_host_ready, rst_a}), 64'({2'd3, 1'b0, 1'b0}));

    // Host valid toggling 1,0,0,1 with a 2-word program.
    do_reset();
    sb_en = 1'b1;
    exp_q.push_back({16'd0, 12'h111});
    exp_q.push_back({16'd1, 12'h222});
    start_load();
    pat = 4'b1001;
    idx = 0;
    for (int c = 0; c < 80 && idx < 2; c++) begin
      host_valid = pat[c % 4];
      host_word  = (idx == 0) ? 12'h111 : 12'h222;
      host_last  = (idx == 1);
      @(negedge in_clock);
      if (hif_a.out_host_ready && (wr_a || run_a || rst_a)) begin
        n_total++;
        $display("FAIL toggle_ready_exclusive: got ready with wr/run/rst, expected ready alone");
      end
      fired = hif_a.out_host_ready && host_valid;
      @(posedge in_clock);
      #1;
      if (fired) idx++;
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
    check("toggle_words_accepted", 64'(idx), 64'd2);
    repeat (4) step();
    in_core_running = 1'b1;
    step();
    in_core_running = 1'b0;
    step();
    check("toggle_done_count", 64'({done_a, cnt_a}), 64'({1'b1, 16'd2}));
    check("toggle_all_writes_seen", 64'(exp_q.size()), 64'd0);
    sb_en = 1'b0;

    // Core that never stops: watchdog (if built in) or indefinite wait.
    do_reset();
    start_load();
    host_send(12'h7FF, 1'b1, 1'b0);
    repeat (3) step();
    check("wd_start_pulse", 64'(run_a), 64'd1);
    step();
    in_core_running = 1'b1;
`ifdef BLOCPU_LOADER_WATCHDOG_EN
    repeat (19) step();
    check("wd_before_expiry", 64'({busy_a, err_a}), 64'({1'b1, 2'd0}));
    step();
    check("wd_expiry", 64'({err_a, rst_a, busy_a}), 64'({2'd2, 1'b1, 1'b0}));
`else
    repeat (40) step();
    check("run_waits_indefinitely", 64'({busy_a, err_a, done_a}), 64'({1'b1, 2'd0, 1'b0}));
    in_core_running = 1'b0;
    step();
    check("run_ends_on_fall", 64'({done_a, err_a}), 64'({1'b1, 2'd0}));
`endif
    in_core_running = 1'b0;

    // Async reset in RUN, then a fresh 1-word load.
    do_reset();
    start_load();
    host_send(12'h123, 1'b1, 1'b0);
    repeat (4) step();
    in_core_running = 1'b1;
    step();
    check("midrun_in_run", 64'({busy_a, done_a}), 64'({1'b1, 1'b0}));
    #2;
    in_reset_n = 1'b0;
    #1;
    check("midrun_async_reset_outputs", 64'(obs_a), 64'd0);
    in_core_running = 1'b0;
    repeat (2) step();
    in_reset_n = 1'b1;
    step();
    sb_en = 1'b1;
    exp_q.push_back({16'd0, 12'h5A5});
    start_load();
    host_send(12'h5A5, 1'b1, 1'b0);
    repeat (4) step();
    in_core_running = 1'b1;
    step();
    in_core_running = 1'b0;
    step();
    check("reload_done_count", 64'({done_a, cnt_a, err_a}), 64'({1'b1, 16'd1, 2'd0}));
    check("reload_all_writes_seen", 64'(exp_q.size()), 64'd0);
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
